param_sync_generator: RTL and testbench

//  Parametrised raster timing generator, successor to the fixed PAL sync generator.

---
 rtl/param_sync_generator_pkg.sv | 31 +++
 rtl/param_sync_generator_if.sv | 28 ++
 rtl/param_sync_generator_int_timer.sv | 37 +++
 rtl/param_sync_generator.sv | 113 +++++++++++
 tb/tb_param_sync_generator.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/param_sync_generator_pkg.sv
// Default PAL/NTSC raster timing constants and the inclusive range-compare helper
// shared by the sync generator blocks.
package video_timing_pkg;

  localparam int unsigned DEF_CW        = 9;
  localparam int unsigned DEF_BPC       = 3;

  localparam int unsigned PAL_H_TOTAL   = 448;
  localparam int unsigned PAL_V_TOTAL   = 312;
  localparam int unsigned NTSC_V_TOTAL  = 262;

  localparam int unsigned PAL_HBLANK_S  = 320;
  localparam int unsigned PAL_HBLANK_E  = 415;
  localparam int unsigned PAL_HSYNC_S   = 344;
  localparam int unsigned PAL_HSYNC_E   = 375;
  localparam int unsigned PAL_VBLANK_S  = 248;
  localparam int unsigned PAL_VBLANK_E  = 255;
  localparam int unsigned PAL_VSYNC_S   = 248;
  localparam int unsigned PAL_VSYNC_E   = 251;

  localparam int unsigned PAL_INT_LINE  = 248;
  localparam int unsigned PAL_INT_HPOS  = 0;
  localparam int unsigned PAL_INT_LEN   = 32;

  function automatic logic in_range(input int unsigned v,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/param_sync_generator_if.sv
// Video timing bundle: pixel-pipeline colour in, DAC-side colour/syncs out, CPU interrupt.
// master = surrounding system, slave = the timing generator.
interface param_sync_generator_if #(
  parameter int unsigned CW  = 9,
  parameter int unsigned BPC = 3
);
  logic           ce;
  logic           mode;
  logic           rasterint_enable;
  logic           vretraceint_disable;
  logic [CW-1:0]  raster_line;
  logic           raster_int_in_progress;
  logic [BPC-1:0] ri, gi, bi;
  logic [BPC-1:0] ro, go, bo;
  logic [CW-1:0]  hcnt, vcnt;
  logic           hsync, vsync, csync;
  logic           int_n;

  modport master (
    output ce, mode, rasterint_enable, vretraceint_disable, raster_line, ri, gi, bi,
    input  raster_int_in_progress, ro, go, bo, hcnt, vcnt, hsync, vsync, csync, int_n
  );

  modport slave (
    input  ce, mode, rasterint_enable, vretraceint_disable, raster_line, ri, gi, bi,
    output raster_int_in_progress, ro, go, bo, hcnt, vcnt, hsync, vsync, csync, int_n
  );
endinterface

// File: rtl/param_sync_generator_int_timer.sv
// Fixed-length interrupt pulse: INT_LEN ce-cycle down-counter that ignores starts while
// running, plus a latch remembering whether the running pulse came from a raster match.
module int_pulse_timer #(
  parameter int unsigned INT_LEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic start,
  input  logic tag_in,
  output logic active,
  output logic tag
);

  localparam int unsigned TW = $clog2(INT_LEN + 1);

  logic [TW-1:0] cnt;
  logic          tag_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      tag_r <= 1'b0;
    end else if (ce) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (start) begin
        cnt   <= TW'(INT_LEN);
        tag_r <= tag_in;
      end
    end
  end

  assign active = (cnt != '0);
  assign tag    = tag_r & active;

endmodule

// File: rtl/param_sync_generator.sv
// Parametrised raster timing generator: live h/v counters, registered syncs and blanked
// colour, and the CPU INT / raster interrupt pulse.
module param_sync_generator
  import video_timing_pkg::*;
#(
  parameter int unsigned CW        = DEF_CW,
  parameter int unsigned BPC       = DEF_BPC,
  parameter int unsigned H_TOTAL   = PAL_H_TOTAL,
  parameter int unsigned V_TOTAL_A = PAL_V_TOTAL,
  parameter int unsigned V_TOTAL_B = NTSC_V_TOTAL,
  parameter int unsigned HBLANK_S  = PAL_HBLANK_S,
  parameter int unsigned HBLANK_E  = PAL_HBLANK_E,
  parameter int unsigned HSYNC_S   = PAL_HSYNC_S,
  parameter int unsigned HSYNC_E   = PAL_HSYNC_E,
  parameter int unsigned VBLANK_S  = PAL_VBLANK_S,
  parameter int unsigned VBLANK_E  = PAL_VBLANK_E,
  parameter int unsigned VSYNC_S   = PAL_VSYNC_S,
  parameter int unsigned VSYNC_E   = PAL_VSYNC_E,
  parameter int unsigned INT_LINE  = PAL_INT_LINE,
  parameter int unsigned INT_HPOS  = PAL_INT_HPOS,
  parameter int unsigned INT_LEN   = PAL_INT_LEN
) (
  input logic                 clk,
  input logic                 rst,
  param_sync_generator_if.slave bus
);

  logic [CW-1:0]  hcnt_p0, vcnt_p0;
  logic           mode_p0;
  logic           h_last, v_last;
  logic           hs_on, vs_on, blank;
  logic           raster_hit, vretrace_hit, int_start;
  logic           int_active, int_tag;
  logic           hsync_p1, vsync_p1, csync_p1;
  logic [BPC-1:0] ro_p1, go_p1, bo_p1;

  assign h_last = (hcnt_p0 == CW'(H_TOTAL - 1));
  assign v_last = (vcnt_p0 == (mode_p0 ? CW'(V_TOTAL_B - 1) : CW'(V_TOTAL_A - 1)));

  // Stage p0: raster position; the frame-rate select is only sampled at the frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= '0;
      mode_p0 <= bus.mode;
    end else if (bus.ce) begin
      if (h_last) begin
        hcnt_p0 <= '0;
        if (v_last) begin
          vcnt_p0 <= '0;
          mode_p0 <= bus.mode;
        end else begin
          vcnt_p0 <= vcnt_p0 + 1'b1;
        end
      end else begin
        hcnt_p0 <= hcnt_p0 + 1'b1;
      end
    end
  end

  assign hs_on = in_range(32'(hcnt_p0), HSYNC_S, HSYNC_E);
  assign vs_on = in_range(32'(vcnt_p0), VSYNC_S, VSYNC_E);
  assign blank = in_range(32'(hcnt_p0), HBLANK_S, HBLANK_E) ||
                 in_range(32'(vcnt_p0), VBLANK_S, VBLANK_E);

  // Stage p1: registered syncs and blanked colour, one ce-cycle behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      csync_p1 <= 1'b1;
      ro_p1    <= '0;
      go_p1    <= '0;
      bo_p1    <= '0;
    end else if (bus.ce) begin
      hsync_p1 <= ~hs_on;
      vsync_p1 <= ~vs_on;
      csync_p1 <= ~(hs_on | vs_on);
      ro_p1    <= blank ? '0 : bus.ri;
      go_p1    <= blank ? '0 : bus.gi;
      bo_p1    <= blank ? '0 : bus.bi;
    end
  end

  // A raster_line beyond the frame height simply never equals vcnt, so it needs no guard
  assign raster_hit   = bus.rasterint_enable && (vcnt_p0 == bus.raster_line);
  assign vretrace_hit = !bus.vretraceint_disable && (vcnt_p0 == CW'(INT_LINE));
  assign int_start    = (hcnt_p0 == CW'(INT_HPOS)) && (raster_hit || vretrace_hit);

  int_pulse_timer #(
    .INT_LEN (INT_LEN)
  ) u_int_timer (
    .clk    (clk),
    .rst    (rst),
    .ce     (bus.ce),
    .start  (int_start),
    .tag_in (raster_hit),
    .active (int_active),
    .tag    (int_tag)
  );

  assign bus.hcnt                   = hcnt_p0;
  assign bus.vcnt                   = vcnt_p0;
  assign bus.hsync                  = hsync_p1;
  assign bus.vsync                  = vsync_p1;
  assign bus.csync                  = csync_p1;
  assign bus.ro                     = ro_p1;
  assign bus.go                     = go_p1;
  assign bus.bo                     = bo_p1;
  assign bus.int_n                  = ~int_active;
  assign bus.raster_int_in_progress = int_tag;

endmodule

// File: tb/tb_param_sync_generator.sv
// Directed + randomized bench for param_sync_generator on a shrunken raster, checked against
// a position/pulse-window reference model.
module tb_param_sync_generator;

  localparam int CW = 6, BPC = 3;
  localparam int H = 32, VA = 20, VB = 14;
  localparam int HBS = 20, HBE = 27, HSS = 22, HSE = 25;
  localparam int VBS = 10, VBE = 12, VSS = 10, VSE = 11;
  localparam int ILINE = 10, IHPOS = 2, ILEN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_sync_generator_if #(.CW(CW), .BPC(BPC)) vif ();

  param_sync_generator #(
    .CW(CW), .BPC(BPC), .H_TOTAL(H), .V_TOTAL_A(VA), .V_TOTAL_B(VB),
    .HBLANK_S(HBS), .HBLANK_E(HBE), .HSYNC_S(HSS), .HSYNC_E(HSE),
    .VBLANK_S(VBS), .VBLANK_E(VBE), .VSYNC_S(VSS), .VSYNC_E(VSE),
    .INT_LINE(ILINE), .INT_HPOS(IHPOS), .INT_LEN(ILEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  int n_cmp = 0, n_err = 0;

  // reference model state
  int pos = 0, ce_idx = 0, pulse_s = 0;
  bit mode_l = 0, pulse_v = 0, pulse_tag = 0;
  bit e_hs = 1, e_vs = 1, e_cs = 1;
  int e_r = 0, e_g = 0, e_b = 0;

  // per-window observation counters
  int int_low_cnt = 0, rip_cnt = 0, hs_low_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int h, v, vtot;
    bit blank, rs, vr, busy;
    if (rst) begin
      pos = 0; mode_l = vif.mode;
      e_hs = 1; e_vs = 1; e_cs = 1; e_r = 0; e_g = 0; e_b = 0;
      pulse_v = 0;
    end else if (vif.ce) begin
      h = pos % H; v = pos / H;
      vtot = mode_l ? VB : VA;
      e_hs = !(h >= HSS && h <= HSE);
      e_vs = !(v >= VSS && v <= VSE);
      e_cs = e_hs && e_vs;
      blank = (h >= HBS && h <= HBE) || (v >= VBS && v <= VBE);
      e_r = blank ? 0 : int'(vif.ri);
      e_g = blank ? 0 : int'(vif.gi);
      e_b = blank ? 0 : int'(vif.bi);
      busy = pulse_v && (ce_idx <= pulse_s + ILEN - 1);
      ce_idx++;
      if (h == IHPOS) begin
        rs = vif.rasterint_enable && (v == int'(vif.raster_line));
        vr = !vif.vretraceint_disable && (v == ILINE);
        if ((rs || vr) && !busy) begin
          pulse_v = 1; pulse_s = ce_idx; pulse_tag = rs;
        end
      end
      if (pos == H * vtot - 1) begin
        pos = 0; mode_l = vif.mode;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic check_all();
    bit low;
    low = pulse_v && (ce_idx >= pulse_s) && (ce_idx <= pulse_s + ILEN - 1);
    chk("hcnt",  32'(vif.hcnt),  32'(pos % H));
    chk("vcnt",  32'(vif.vcnt),  32'(pos / H));
    chk("ro",    32'(vif.ro),    32'(e_r));
    chk("go",    32'(vif.go),    32'(e_g));
    chk("bo",    32'(vif.bo),    32'(e_b));
    chk("hsync", 32'(vif.hsync), 32'(e_hs));
    chk("vsync", 32'(vif.vsync), 32'(e_vs));
    chk("csync", 32'(vif.csync), 32'(e_cs));
    chk("int_n", 32'(vif.int_n), 32'(!low));
    chk("rip",   32'(vif.raster_int_in_progress), 32'(low && pulse_tag));
    if (vif.int_n === 1'b0) int_low_cnt++;
    if (vif.raster_int_in_progress === 1'b1) rip_cnt++;
    if (vif.hsync === 1'b0) hs_low_cnt++;
  endtask

  task automatic step(input logic ce_v);
    vif.ce = ce_v;
    vif.ri = 3'($urandom);
    vif.gi = 3'($urandom);
    vif.bi = 3'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // run with ce=1 from (0,0) until the counters are back at (0,0); optionally flip mode mid-way
  task automatic frame_len(input int switch_at, output int n);
    n = 0;
    do begin
      step(1'b1);
      n++;
      if (n == switch_at) vif.mode = ~vif.mode;
    end while (!(vif.hcnt == '0 && vif.vcnt == '0) && n < 2000);
  endtask

  task automatic clr_obs();
    int_low_cnt = 0; rip_cnt = 0; hs_low_cnt = 0;
  endtask

  initial begin
    int n;
    logic [CW-1:0] hold_h, hold_v;
    bit seen;
    vif.ce = 1'b1; vif.mode = 1'b0;
    vif.rasterint_enable = 1'b0; vif.vretraceint_disable = 1'b1;
    vif.raster_line = '0;
    vif.ri = '0; vif.gi = '0; vif.bi = '0;

    // reset held 3 cycles with ce=1
    rst = 1'b1;
    repeat (3) step(1'b1);
    chk("rst_int_n", 32'(vif.int_n), 32'd1);
    chk("rst_csync", 32'(vif.csync), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_hcnt", 32'(vif.hcnt), 32'(i));
      step(1'b1);
    end

    // align to a frame start, then measure a 50 Hz frame
    frame_len(0, n);
    clr_obs();
    frame_len(0, n);
    chk("frame_a_len", 32'(n), 32'(H * VA));
    chk("hsync_low_per_frame", 32'(hs_low_cnt), 32'((HSE - HSS + 1) * VA));
    chk("no_int_disabled", 32'(int_low_cnt), 32'd0);

    // mode flipped at line 5: this frame stays long, the next one is short
    frame_len(5 * H, n);
    chk("frame_switch_len", 32'(n), 32'(H * VA));
    frame_len(0, n);
    chk("frame_b_len", 32'(n), 32'(H * VB));

    // raster interrupt only
    vif.rasterint_enable = 1'b1; vif.raster_line = 6'd6; vif.vretraceint_disable = 1'b1;
    clr_obs(); frame_len(0, n);
    chk("raster_int_len", 32'(int_low_cnt), 32'(ILEN));
    chk("raster_rip_len", 32'(rip_cnt), 32'(ILEN));

    // raster and vretrace on the same line: one pulse, tagged raster
    vif.raster_line = 6'(ILINE); vif.vretraceint_disable = 1'b0;
    clr_obs(); frame_len(0, n);
    chk("both_int_len", 32'(int_low_cnt), 32'(ILEN));
    chk("both_rip_len", 32'(rip_cnt), 32'(ILEN));

    // vretrace only
    vif.rasterint_enable = 1'b0;
    clr_obs(); frame_len(0, n);
    chk("vr_int_len", 32'(int_low_cnt), 32'(ILEN));
    chk("vr_rip_len", 32'(rip_cnt), 32'd0);

    // raster lines past the end of the short frame never fire
    vif.rasterint_enable = 1'b1; vif.vretraceint_disable = 1'b1; vif.raster_line = 6'd20;
    clr_obs(); frame_len(0, n);
    chk("raster_20_none", 32'(int_low_cnt), 32'd0);
    vif.raster_line = 6'd40;
    clr_obs(); frame_len(0, n);
    chk("raster_40_none", 32'(int_low_cnt), 32'd0);

    // ce gating hold
    hold_h = vif.hcnt; hold_v = vif.vcnt;
    step(1'b0);
    chk("ce_hold_h", 32'(vif.hcnt), 32'(hold_h));
    chk("ce_hold_v", 32'(vif.vcnt), 32'(hold_v));

    // randomized ce, enables, raster line and mode
    for (int i = 0; i < 3000; i++) begin
      if ((i % 37) == 0) begin
        vif.rasterint_enable    = 1'($urandom);
        vif.vretraceint_disable = 1'($urandom);
        vif.raster_line         = 6'($urandom_range(0, 15));
      end
      if ((i % 211) == 0) vif.mode = 1'($urandom);
      step(1'($urandom));
    end

    // reset in the middle of a pulse
    vif.rasterint_enable = 1'b1; vif.raster_line = 6'd3; vif.vretraceint_disable = 1'b1;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step(1'b1);
      if (vif.int_n === 1'b0) seen = 1;
    end
    chk("pulse_seen", 32'(seen), 32'd1);
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    chk("rst_mid_pulse_int_n", 32'(vif.int_n), 32'd1);
    chk("rst_mid_pulse_rip", 32'(vif.raster_int_in_progress), 32'd0);
    rst = 1'b0;
    repeat (4) step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
